// File: rtl/riscv_biu_pkg.sv
// Shared types for the instruction-fetch bus interface unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_biu_pkg;

    localparam int BIU_XLEN        = 32;
    localparam int BIU_PARCEL_SIZE = 32;

    // Canonical NOP (addi x0,x0,0); must stay identical to the core package value.
    localparam logic [BIU_PARCEL_SIZE-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } biu_state_e;

    typedef struct packed {
        logic [BIU_XLEN-1:0]        pc;
        logic [BIU_PARCEL_SIZE-1:0] parcel;
        logic                       misaligned;
        logic                       page_fault;
    } biu_entry_t;

endpackage

// File: rtl/riscv_if_biu_fifo.sv
// Synchronous DEPTH-entry FIFO with a clear input that empties it at the edge.
// Latency: push visible at pop_dat one cycle later; pop_dat is the registered head.
// Backpressure: none internally; pushes when full and pops when empty are ignored.
// Ports: clk/rstn (sync active-low), clr, push/push_dat, pop/pop_dat, empty, count.
module riscv_if_biu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !clr && (count_q != CNT_FULL);
        do_pop   = pop && !clr && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
            if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/riscv_if_biu.sv
// Instruction-fetch BIU: turns IF next-PC into word fetches and returns in-order parcels.
// Latency: ack cycle -> rvalid cycle -> parcel at IF on the following cycle.
// Backpressure: DEPTH credits shared by in-flight requests and buffered parcels; if_stall holds the head.
// Ports: IF side (if_nxt_pc/stall/flush in, if_stall_nxt_pc and if_parcel* out),
//        memory side (mem_req/mem_adr out, mem_ack/mem_rvalid/mem_rdata/mem_err in).
module riscv_if_biu
    import riscv_biu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PARCEL_SIZE = 32,
    parameter int DEPTH       = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [XLEN-1:0]           if_nxt_pc,
    input  logic                      if_stall,
    input  logic                      if_flush,
    output logic                      if_stall_nxt_pc,
    output logic [PARCEL_SIZE-1:0]    if_parcel,
    output logic [XLEN-1:0]           if_parcel_pc,
    output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
    output logic                      if_parcel_misaligned,
    output logic                      if_parcel_page_fault,
    output logic                      mem_req,
    output logic [XLEN-1:0]           mem_adr,
    input  logic                      mem_ack,
    input  logic                      mem_rvalid,
    input  logic [PARCEL_SIZE-1:0]    mem_rdata,
    input  logic                      mem_err
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CREDITS = CW'(DEPTH);

    biu_state_e    state_q, state_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [CW-1:0]   tag_count, rsp_count, used;
    logic [XLEN-1:0] tag_pc;
    logic            tag_empty, rsp_empty;
    biu_entry_t      rsp_push_dat, rsp_head;
    logic            issue, pc_aligned, ack_fire, mis_fire;
    logic            rv_live, rsp_fire, rsp_push, rsp_pop, parcel_vld;

    always_comb begin
        used       = tag_count + rsp_count;
        pc_aligned = (if_nxt_pc[1:0] == 2'b00);
        issue      = rstn && (state_q == ST_RUN) && !if_flush && !if_stall && (used < CREDITS);
        mem_req    = issue && pc_aligned;
        mem_adr    = {if_nxt_pc[XLEN-1:2], 2'b00};
        ack_fire   = mem_req && mem_ack;
        // A misaligned PC becomes a NOP entry straight into the response FIFO; it waits
        // for the tag queue to empty so it cannot overtake earlier bus responses.
        mis_fire        = issue && !pc_aligned && tag_empty;
        if_stall_nxt_pc = !(ack_fire || mis_fire);

        // A response only counts while something is in flight; strays are dropped.
        rv_live  = mem_rvalid && !tag_empty;
        rsp_fire = rstn && rv_live && (state_q == ST_RUN) && !if_flush;
        rsp_push = rsp_fire || mis_fire;

        if (mis_fire) begin
            rsp_push_dat.pc         = if_nxt_pc;
            rsp_push_dat.parcel     = INSTR_NOP;
            rsp_push_dat.misaligned = 1'b1;
            rsp_push_dat.page_fault = 1'b0;
        end else begin
            rsp_push_dat.pc         = tag_pc;
            rsp_push_dat.parcel     = mem_rdata;
            rsp_push_dat.misaligned = 1'b0;
            rsp_push_dat.page_fault = mem_err;
        end

        parcel_vld      = rstn && !rsp_empty && !if_flush;
        rsp_pop         = parcel_vld && !if_stall;
        if_parcel_valid = {(PARCEL_SIZE/16){parcel_vld}};
        if (parcel_vld) begin
            if_parcel            = rsp_head.parcel;
            if_parcel_pc         = rsp_head.pc;
            if_parcel_misaligned = rsp_head.misaligned;
            if_parcel_page_fault = rsp_head.page_fault;
        end else begin
            if_parcel            = INSTR_NOP;
            if_parcel_pc         = '0;
            if_parcel_misaligned = 1'b0;
            if_parcel_page_fault = 1'b0;
        end
    end

    // Flush abandons in-flight fetches; DRAIN swallows their responses before new
    // requests may go out, so tags never get paired with stale data.
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        case (state_q)
            ST_RUN: begin
                if (if_flush && (tag_count - CW'(rv_live)) != '0) begin
                    state_d   = ST_DRAIN;
                    discard_d = tag_count - CW'(rv_live);
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid) begin
                    discard_d = discard_q - CW'(1);
                    if (discard_q == CW'(1)) state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_RUN;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    riscv_if_biu_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (if_flush),
        .push     (ack_fire),
        .push_dat (if_nxt_pc),
        .pop      (rsp_fire),
        .pop_dat  (tag_pc),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    riscv_if_biu_fifo #(.WIDTH($bits(biu_entry_t)), .DEPTH(DEPTH)) u_rsp_q (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (if_flush),
        .push     (rsp_push),
        .push_dat (rsp_push_dat),
        .pop      (rsp_pop),
        .pop_dat  (rsp_head),
        .empty    (rsp_empty),
        .count    (rsp_count)
    );

endmodule

// File: tb/tb_riscv_if_biu.sv
// Bench for riscv_if_biu: in-order bus memory model plus a parcel scoreboard.
// Latency: n/a.
// Backpressure: random if_stall / mem_ack / mem_rvalid.
module tb_riscv_if_biu;
    import riscv_biu_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] if_nxt_pc;
    logic        if_stall, if_flush;
    logic        if_stall_nxt_pc;
    logic [31:0] if_parcel, if_parcel_pc;
    logic [1:0]  if_parcel_valid;
    logic        if_parcel_misaligned, if_parcel_page_fault;
    logic        mem_req;
    logic [31:0] mem_adr;
    logic        mem_ack, mem_rvalid, mem_err;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    riscv_if_biu #(.XLEN(32), .PARCEL_SIZE(32), .DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .if_nxt_pc            (if_nxt_pc),
        .if_stall             (if_stall),
        .if_flush             (if_flush),
        .if_stall_nxt_pc      (if_stall_nxt_pc),
        .if_parcel            (if_parcel),
        .if_parcel_pc         (if_parcel_pc),
        .if_parcel_valid      (if_parcel_valid),
        .if_parcel_misaligned (if_parcel_misaligned),
        .if_parcel_page_fault (if_parcel_page_fault),
        .mem_req              (mem_req),
        .mem_adr              (mem_adr),
        .mem_ack              (mem_ack),
        .mem_rvalid           (mem_rvalid),
        .mem_rdata            (mem_rdata),
        .mem_err              (mem_err)
    );

    // A fetch the IF has handed over; ready once its data is known to the BIU.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit          mis;
        bit          fault;
        bit          ready;
    } exp_t;

    // A request accepted by memory, tagged with the flush/reset epoch it belongs to.
    typedef struct {
        logic [31:0] adr;
        int          ep;
    } req_t;

    exp_t exp_q[$];
    exp_t dlog[$];
    req_t mq[$];

    int          epoch  = 0;
    int          rst_ep = 0;
    int          n_vec  = 0;
    int          n_err  = 0;
    int          p_ack = 0, p_rv = 0, p_stall = 0, p_err = 0;
    bit          fixed_data = 0;
    logic [31:0] ifpc = 32'h200;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic lit(input string name, input int idx, input logic [31:0] pc, input bit mis,
                       input bit flt, input bit use_data, input logic [31:0] data);
        n_vec++;
        if (idx >= dlog.size()) begin
            n_err++;
            $display("FAIL %s: parcel #%0d never delivered (%0d delivered)", name, idx, dlog.size());
        end else if (dlog[idx].pc !== pc || dlog[idx].mis !== mis || dlog[idx].fault !== flt ||
                     (use_data && dlog[idx].data !== data)) begin
            n_err++;
            $display("FAIL %s: got pc=%h data=%h mis=%0d pf=%0d, want pc=%h mis=%0d pf=%0d",
                     name, dlog[idx].pc, dlog[idx].data, dlog[idx].mis, dlog[idx].fault, pc, mis, flt);
        end
    endtask

    // One clock: drive inputs just after the edge, check and advance the model at negedge.
    task automatic cycle(input bit flush, input logic [31:0] fpc, input bit rst);
        int   old_cnt, cur_cnt;
        bit   stale, can, e_req, e_cons, e_vld, found;
        req_t r;
        exp_t e;

        @(posedge clk);
        #1;
        stale = 0;
        foreach (mq[i]) if (mq[i].ep < rst_ep) stale = 1;
        rstn       = !rst;
        if_flush   = flush;
        if_nxt_pc  = ifpc;
        if_stall   = stale || ($urandom_range(99) < p_stall);
        mem_ack    = ($urandom_range(99) < p_ack);
        mem_rvalid = (mq.size() > 0) && ($urandom_range(99) < p_rv);
        mem_rdata  = fixed_data ? 32'h0000_0013 : $urandom;
        mem_err    = ($urandom_range(99) < p_err);

        @(negedge clk);
        old_cnt = 0;
        foreach (mq[i]) if (mq[i].ep != epoch) old_cnt++;
        cur_cnt = mq.size() - old_cnt;

        can    = !rst && !flush && !if_stall && old_cnt == 0 && exp_q.size() < DEPTH;
        e_req  = can && ifpc[1:0] == 2'b00;
        e_cons = (e_req && mem_ack) || (can && ifpc[1:0] != 2'b00 && cur_cnt == 0);
        e_vld  = !rst && !flush && exp_q.size() > 0 && exp_q[0].ready;

        chk("mem_req", mem_req, e_req);
        if (e_req) chk("mem_adr", mem_adr, {ifpc[31:2], 2'b00});
        chk("stall_nxt_pc", if_stall_nxt_pc, !e_cons);
        chk("parcel_valid", if_parcel_valid, e_vld ? 2'b11 : 2'b00);
        if (e_vld) begin
            chk("parcel_pc", if_parcel_pc, exp_q[0].pc);
            chk("parcel_data", if_parcel, exp_q[0].data);
            chk("parcel_flags", {if_parcel_misaligned, if_parcel_page_fault},
                {exp_q[0].mis, exp_q[0].fault});
        end
        if (rst) begin
            chk("rst_parcel", if_parcel, INSTR_NOP);
            chk("rst_pc", if_parcel_pc, 32'h0);
            chk("rst_flags", {if_parcel_misaligned, if_parcel_page_fault}, 2'b00);
        end

        if (e_vld && !if_stall) dlog.push_back(exp_q.pop_front());
        if (mem_rvalid) begin
            r = mq.pop_front();
            if (r.ep == epoch) begin
                found = 0;
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (!found && !exp_q[i].ready) begin
                        exp_q[i].data  = mem_rdata;
                        exp_q[i].fault = mem_err;
                        exp_q[i].ready = 1;
                        found = 1;
                    end
                end
            end
        end
        if (e_req && mem_ack) begin
            r.adr = {ifpc[31:2], 2'b00};
            r.ep  = epoch;
            mq.push_back(r);
            e.pc = ifpc; e.data = 32'h0; e.mis = 0; e.fault = 0; e.ready = 0;
            exp_q.push_back(e);
        end else if (e_cons) begin
            e.pc = ifpc; e.data = INSTR_NOP; e.mis = 1; e.fault = 0; e.ready = 1;
            exp_q.push_back(e);
        end
        if (e_cons) ifpc = ifpc + 32'd4;
        if (flush) begin
            exp_q.delete();
            epoch++;
            ifpc = fpc;
        end
        if (rst) begin
            exp_q.delete();
            epoch++;
            rst_ep = epoch;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 32'h0, 0);
    endtask

    initial begin
        int base;
        logic [31:0] tpc;
        bit f, rs;

        rstn = 0; if_nxt_pc = '0; if_stall = 0; if_flush = 0;
        mem_ack = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;

        // Reset, then a request left unaccepted for three cycles.
        ifpc = 32'h200;
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0);
            chk("hold_req", mem_req, 1'b1);
            chk("hold_adr", mem_adr, 32'h200);
            chk("hold_stall_nxt", if_stall_nxt_pc, 1'b1);
            chk("hold_no_parcel", if_parcel_valid, 2'b00);
        end

        // Streaming with ack every cycle and one-cycle response latency.
        p_ack = 100; p_rv = 100; fixed_data = 1;
        base = dlog.size();
        run(10);
        lit("stream0", base,     32'h200, 0, 0, 1, 32'h13);
        lit("stream1", base + 1, 32'h204, 0, 0, 1, 32'h13);
        lit("stream2", base + 2, 32'h208, 0, 0, 1, 32'h13);
        fixed_data = 0;

        // Quiesce at 0x500, then two responses buffered under if_stall.
        p_ack = 0;
        cycle(1, 32'h500, 0);
        run(6);
        p_rv = 0; p_ack = 100;
        run(2);
        p_stall = 100; p_rv = 100;
        base = dlog.size();
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0);
            chk("stall_no_req", mem_req, 1'b0);
        end
        p_stall = 0; p_ack = 0;
        run(6);
        lit("stall_rel0", base,     32'h500, 0, 0, 0, 32'h0);
        lit("stall_rel1", base + 1, 32'h504, 0, 0, 0, 32'h0);

        // Flush with two requests in flight: their responses must vanish.
        p_ack = 100; p_rv = 0;
        run(2);
        cycle(1, 32'h400, 0);
        base = dlog.size();
        p_rv = 100;
        run(8);
        lit("flush_first", base, 32'h400, 0, 0, 0, 32'h0);

        // Misaligned PC becomes a NOP parcel without a bus request.
        cycle(1, 32'h202, 0);
        base = dlog.size();
        run(8);
        lit("misaligned", base, 32'h202, 1, 0, 1, INSTR_NOP);

        // Bus error becomes a page fault.
        p_err = 100;
        cycle(1, 32'h300, 0);
        base = dlog.size();
        run(8);
        lit("page_fault", base, 32'h300, 0, 1, 0, 32'h0);
        p_err = 0;

        // Reset with two in flight; their late responses must be ignored.
        p_ack = 0; p_rv = 100;
        run(6);
        p_ack = 100; p_rv = 0;
        run(2);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        chk("post_rst_no_req", mem_req, 1'b0);
        chk("post_rst_no_parcel", if_parcel_valid, 2'b00);
        p_rv = 100;
        run(8);

        // Random traffic.
        p_ack = 60; p_rv = 60; p_stall = 20; p_err = 10;
        for (int i = 0; i < 3000; i++) begin
            rs  = ($urandom_range(999) < 3);
            f   = !rs && ($urandom_range(99) < 4);
            tpc = $urandom;
            tpc[1:0] = ($urandom_range(9) == 0) ? 2'b10 : 2'b00;
            cycle(f, tpc, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
